// File: rtl/hazard_ctrl.sv
// Decode-side hazard unit: a shadow scoreboard of in-flight destination registers raises
// the stall/hold controls, and a two-state FSM squashes fetch after a jump-register.
module hazard_ctrl #(
  parameter int FORWARDING     = 1,
  parameter int WB_WRITE_FIRST = 1,
  parameter int JR_PENALTY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_reg_write,
  input  logic        id_mem_load,
  input  logic        id_jump_reg,
  input  logic [4:0]  id_dest,
  output logic        stall,
  output logic        pc_hold,
  output logic        ifid_hold,
  output logic        ifid_flush,
  output logic [15:0] stall_count
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t      state, state_nxt;
  logic [2:0]  flush_cnt, flush_cnt_nxt;

  // Scoreboard entries: _p0 = EX, _p1 = MEM, _p2 = WB.
  logic        vld_p0, vld_p1, vld_p2;
  logic [4:0]  dest_p0, dest_p1, dest_p2;
  logic        ld_p0, ld_p1, ld_p2;

  logic        hit_p0, hit_p1, hit_p2;
  logic        hazard;
  logic        issue;
  logic        jr_issue;

  // A valid entry whose nonzero destination is read by the decode instruction.
  // rs==rt collapses into one hit because the two reads are OR-ed.
  function automatic logic src_hit(input logic v, input logic [4:0] dest);
    logic rd_rs, rd_rt;
    rd_rs = id_uses_rs && (dest == id_rs);
    rd_rt = id_uses_rt && (dest == id_rt);
    return v && (dest != 5'd0) && (rd_rs || rd_rt);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  always_comb begin
    hit_p0 = src_hit(vld_p0, dest_p0);
    hit_p1 = src_hit(vld_p1, dest_p1);
    hit_p2 = src_hit(vld_p2, dest_p2);
    if (FORWARDING != 0) begin
      hazard = id_valid && hit_p0 && ld_p0;
    end else begin
      hazard = id_valid && (hit_p0 || hit_p1 || ((WB_WRITE_FIRST == 0) && hit_p2));
    end
    issue    = id_valid && !hazard;
    jr_issue = issue && id_jump_reg;
  end

  // ---- decode -> EX -> MEM -> WB scoreboard advance ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p0 <= issue && id_reg_write && (id_dest != 5'd0);
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  always_ff @(posedge clk) begin
    dest_p0 <= id_dest;
    ld_p0   <= id_mem_load;
    dest_p1 <= dest_p0;
    ld_p1   <= ld_p0;
    dest_p2 <= dest_p1;
    ld_p2   <= ld_p1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= 16'd0;
    end else if (hazard) begin
      stall_count <= sat_inc(stall_count);
    end
  end

  // ---- jump-register fetch squash FSM ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      flush_cnt <= 3'd0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    case (state)
      RUN: begin
        if (jr_issue) begin
          state_nxt     = FLUSH;
          flush_cnt_nxt = 3'(JR_PENALTY);
        end
      end
      FLUSH: begin
        flush_cnt_nxt = flush_cnt - 3'd1;
        if (flush_cnt == 3'd1) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt     = RUN;
        flush_cnt_nxt = 3'd0;
      end
    endcase
  end

  always_comb begin
    stall      = hazard && !reset;
    pc_hold    = hazard && !reset;
    ifid_hold  = hazard && !reset;
    ifid_flush = (state == FLUSH) && !reset;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three parameterisations driven from shared decode inputs,
// checked by vector tables, a saturation run and a queue-based random reference model.
module tb_hazard_ctrl;

  localparam int P = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_load, id_jump_reg;
  logic [4:0] id_rs, id_rt, id_dest;

  logic        st[3];
  logic        ph[3];
  logic        ih[3];
  logic        fo[3];
  logic [15:0] cnt[3];

  // Index 0: forwarding; 1: no forwarding, write-first RF; 2: no forwarding, WB checked.
  int FW[3]  = '{1, 0, 0};
  int WBF[3] = '{1, 1, 0};

  hazard_ctrl #(.FORWARDING(1), .WB_WRITE_FIRST(1), .JR_PENALTY(P)) u_f1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
    .id_mem_load(id_mem_load), .id_jump_reg(id_jump_reg), .id_dest(id_dest),
    .stall(st[0]), .pc_hold(ph[0]), .ifid_hold(ih[0]), .ifid_flush(fo[0]),
    .stall_count(cnt[0]));

  hazard_ctrl #(.FORWARDING(0), .WB_WRITE_FIRST(1), .JR_PENALTY(P)) u_f0w1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
    .id_mem_load(id_mem_load), .id_jump_reg(id_jump_reg), .id_dest(id_dest),
    .stall(st[1]), .pc_hold(ph[1]), .ifid_hold(ih[1]), .ifid_flush(fo[1]),
    .stall_count(cnt[1]));

  hazard_ctrl #(.FORWARDING(0), .WB_WRITE_FIRST(0), .JR_PENALTY(P)) u_f0w0 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
    .id_mem_load(id_mem_load), .id_jump_reg(id_jump_reg), .id_dest(id_dest),
    .stall(st[2]), .pc_hold(ph[2]), .ifid_hold(ih[2]), .ifid_flush(fo[2]),
    .stall_count(cnt[2]));

  typedef struct packed {
    logic       rst;
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       rw;
    logic       ld;
    logic       jr;
    logic [4:0] dest;
  } in_t;

  typedef struct {
    in_t        i;
    logic [0:2] s;
    logic [0:2] f;
    bit         cc;
    int         c[3];
  } vec_t;

  typedef struct {
    bit w;
    int dest;
    bit ld;
  } rec_t;

  int   total = 0;
  int   bad   = 0;
  vec_t tbl[$];

  function automatic in_t mk(bit rst, bit v, int rs, int rt, bit urs, bit urt,
                             bit rw, bit ld, bit jr, int dest);
    in_t x;
    x.rst = rst; x.v = v; x.rs = 5'(rs); x.rt = 5'(rt); x.urs = urs; x.urt = urt;
    x.rw = rw; x.ld = ld; x.jr = jr; x.dest = 5'(dest);
    return x;
  endfunction

  task automatic row(in_t x, logic [0:2] s, logic [0:2] f, bit cc, int c0, int c1, int c2);
    vec_t r;
    r.i = x; r.s = s; r.f = f; r.cc = cc;
    r.c[0] = c0; r.c[1] = c1; r.c[2] = c2;
    tbl.push_back(r);
  endtask

  task automatic drive(in_t x);
    reset = x.rst; id_valid = x.v; id_rs = x.rs; id_rt = x.rt;
    id_uses_rs = x.urs; id_uses_rt = x.urt; id_reg_write = x.rw;
    id_mem_load = x.ld; id_jump_reg = x.jr; id_dest = x.dest;
  endtask

  task automatic chk(string name, int k, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%0d want=%0d t=%0t", name, k, act, exp, $time);
    end
  endtask

  task automatic chk_dut(string tag, int k, bit es, bit ef, bit cc, int ec);
    chk({tag, ".stall"}, k, int'(st[k]), int'(es));
    chk({tag, ".pc_hold"}, k, int'(ph[k]), int'(es));
    chk({tag, ".ifid_hold"}, k, int'(ih[k]), int'(es));
    chk({tag, ".ifid_flush"}, k, int'(fo[k]), int'(ef));
    if (cc) chk({tag, ".stall_count"}, k, int'(cnt[k]), ec);
  endtask

  // Reference model: issue history per configuration, youngest first.
  rec_t hist[3][$];
  int   last_jr[3];
  int   mcnt[3];

  function automatic bit mhaz(int k, in_t x);
    rec_t e;
    bit   reads, in_win;
    if (!x.v) return 1'b0;
    for (int d = 1; d <= hist[k].size(); d++) begin
      e = hist[k][d-1];
      reads = e.w && ((x.urs && e.dest == int'(x.rs)) || (x.urt && e.dest == int'(x.rt)));
      if (FW[k] != 0) in_win = (d == 1) && e.ld;
      else            in_win = (d <= 2) || (d == 3 && WBF[k] == 0);
      if (reads && in_win) return 1'b1;
    end
    return 1'b0;
  endfunction

  initial begin
    in_t NOP, RST, LW5, A, ADD5, B, LW0, U0, ST9, U9, JR, LW31, A_RST, x;
    bit  h[3], fl[3], any_fl;
    rec_t r;
    int  cyc;

    NOP   = mk(0,0, 0, 0,0,0,0,0,0, 0);
    RST   = mk(1,0, 0, 0,0,0,0,0,0, 0);
    LW5   = mk(0,1, 0, 0,0,0,1,1,0, 5);
    A     = mk(0,1, 5, 1,1,1,1,0,0, 6);
    A_RST = mk(1,1, 5, 1,1,1,1,0,0, 6);
    ADD5  = mk(0,1, 0, 0,0,0,1,0,0, 5);
    B     = mk(0,1, 5, 5,1,1,1,0,0, 7);
    LW0   = mk(0,1, 0, 0,0,0,1,1,0, 0);
    U0    = mk(0,1, 0, 0,1,1,1,0,0, 8);
    ST9   = mk(0,1, 0, 0,0,0,0,0,0, 9);
    U9    = mk(0,1, 9, 9,1,1,0,0,0, 0);
    JR    = mk(0,1,31, 0,1,0,0,0,1, 0);
    LW31  = mk(0,1, 0, 0,0,0,1,1,0,31);

    row(RST,  3'b000, 3'b000, 0, 0,0,0);
    row(RST,  3'b000, 3'b000, 1, 0,0,0);
    row(NOP,  3'b000, 3'b000, 1, 0,0,0);
    // load-use, then a dependent held in decode
    row(LW5,  3'b000, 3'b000, 1, 0,0,0);
    row(A,    3'b111, 3'b000, 1, 0,0,0);
    row(A,    3'b011, 3'b000, 1, 1,1,1);
    row(A,    3'b001, 3'b000, 1, 1,2,2);
    row(NOP,  3'b000, 3'b000, 1, 1,2,3);
    repeat (3) row(NOP, 3'b000, 3'b000, 1, 1,2,3);
    // ALU producer, consumer reads it twice
    row(ADD5, 3'b000, 3'b000, 1, 1,2,3);
    row(B,    3'b011, 3'b000, 1, 1,2,3);
    row(B,    3'b011, 3'b000, 1, 1,3,4);
    row(B,    3'b001, 3'b000, 1, 1,4,5);
    row(B,    3'b000, 3'b000, 1, 1,4,6);
    repeat (3) row(NOP, 3'b000, 3'b000, 1, 1,4,6);
    // r0 and non-writing producers never hit
    row(LW0,  3'b000, 3'b000, 1, 1,4,6);
    row(U0,   3'b000, 3'b000, 1, 1,4,6);
    row(NOP,  3'b000, 3'b000, 1, 1,4,6);
    row(ST9,  3'b000, 3'b000, 1, 1,4,6);
    row(U9,   3'b000, 3'b000, 1, 1,4,6);
    repeat (3) row(NOP, 3'b000, 3'b000, 1, 1,4,6);
    // plain jr: flush window of P cycles
    row(JR,   3'b000, 3'b000, 1, 1,4,6);
    row(NOP,  3'b000, 3'b111, 1, 1,4,6);
    row(NOP,  3'b000, 3'b111, 1, 1,4,6);
    row(NOP,  3'b000, 3'b000, 1, 1,4,6);
    // jr behind a load of its source: hazard first, then flush
    row(LW31, 3'b000, 3'b000, 1, 1,4,6);
    row(JR,   3'b111, 3'b000, 1, 1,4,6);
    row(JR,   3'b011, 3'b000, 1, 2,5,7);
    row(JR,   3'b001, 3'b100, 1, 2,6,8);
    row(JR,   3'b000, 3'b110, 1, 2,6,9);
    row(NOP,  3'b000, 3'b011, 1, 2,6,9);
    row(NOP,  3'b000, 3'b001, 1, 2,6,9);
    row(NOP,  3'b000, 3'b000, 1, 2,6,9);
    // reset during a stall
    row(LW5,  3'b000, 3'b000, 1, 2,6,9);
    row(A,    3'b111, 3'b000, 1, 2,6,9);
    row(A_RST,3'b000, 3'b000, 1, 3,7,10);
    row(A,    3'b000, 3'b000, 1, 0,0,0);
    row(NOP,  3'b000, 3'b000, 1, 0,0,0);
    // reset during the flush window
    row(JR,   3'b000, 3'b000, 1, 0,0,0);
    row(NOP,  3'b000, 3'b111, 1, 0,0,0);
    row(RST,  3'b000, 3'b000, 1, 0,0,0);
    row(NOP,  3'b000, 3'b000, 1, 0,0,0);
    row(NOP,  3'b000, 3'b000, 1, 0,0,0);

    drive(RST);
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].i);
      #1;
      for (int k = 0; k < 3; k++)
        chk_dut($sformatf("vec%0d", i), k, tbl[i].s[k], tbl[i].f[k], tbl[i].cc, tbl[i].c[k]);
    end

    // Saturation: pin a load to r5 in EX of the forwarding unit so every cycle is a hazard.
    @(negedge clk); drive(RST);
    @(negedge clk);
    force u_f1.vld_p0  = 1'b1;
    force u_f1.dest_p0 = 5'd5;
    force u_f1.ld_p0   = 1'b1;
    drive(mk(0,1,5,0,1,0,0,0,0,0));
    repeat (100) @(negedge clk);
    #1;
    chk("sat.early_count", 0, int'(cnt[0]), 100);
    repeat (69900) @(negedge clk);
    #1;
    chk("sat.count", 0, int'(cnt[0]), 65535);
    chk("sat.stall", 0, int'(st[0]), 1);
    release u_f1.vld_p0;
    release u_f1.dest_p0;
    release u_f1.ld_p0;

    // Random traffic against the reference model.
    cyc = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      x = mk(($urandom_range(0,99) == 0) || n < 2, ($urandom_range(0,9) < 8),
             $urandom_range(0,7), $urandom_range(0,7), $urandom_range(0,1),
             $urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,2) == 0,
             $urandom_range(0,19) == 0, $urandom_range(0,7));
      any_fl = 1'b0;
      for (int k = 0; k < 3; k++) begin
        fl[k] = (n >= 2) && (cyc - last_jr[k] >= 1) && (cyc - last_jr[k] <= P);
        any_fl |= fl[k];
      end
      if (any_fl) x.v = 1'b0;
      drive(x);
      #1;
      for (int k = 0; k < 3; k++) begin
        h[k] = !x.rst && mhaz(k, x);
        chk_dut("rnd", k, h[k], !x.rst && fl[k], n >= 2, mcnt[k]);
      end
      for (int k = 0; k < 3; k++) begin
        if (x.rst) begin
          hist[k].delete();
          last_jr[k] = -100;
          mcnt[k] = 0;
        end else begin
          r.w = x.v && !h[k] && x.rw && (x.dest != 5'd0);
          r.dest = int'(x.dest);
          r.ld = x.ld;
          hist[k].push_front(r);
          if (hist[k].size() > 3) void'(hist[k].pop_back());
          if (x.v && !h[k] && x.jr && !fl[k]) last_jr[k] = cyc;
          if (h[k] && mcnt[k] < 65535) mcnt[k]++;
        end
      end
      cyc++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
